// File: rtl/compute_unit_mlane_pkg.sv
// Shared types and helpers for the multi-lane sparse compute unit.
//   state_e     : control FSM states (IDLE, COMPUTE, OUT)
//   MAX_BUS     : widest chunk any instance may use (BUS_SIZE must not exceed it)
//   IDX_W       : width of a position / rank index within a chunk
//   rank_below  : number of set map bits strictly below a position, i.e. the
//                 packed-nonzero rank of that position
package cu_pkg;

  localparam int unsigned MAX_BUS = 64;
  localparam int unsigned IDX_W   = $clog2(MAX_BUS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] rank_below(input logic [MAX_BUS-1:0] map,
                                                  input int unsigned        pos);
    logic [IDX_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_BUS; i++) begin
      if (i < pos && map[i]) cnt = cnt + 1'b1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/compute_unit_mlane_match_picker.sv
// Combinational selector of the lowest set positions of a match mask.
//   remaining : positions still to be consumed
//   lane_pos  : position taken by each lane (lane 0 = lowest)
//   lane_vld  : lane carries a real position
//   next_mask : remaining with the taken positions cleared
module match_picker
  import cu_pkg::*;
#(
  parameter int unsigned BUS_SIZE = 8,
  parameter int unsigned LANES    = 2
) (
  input  logic [BUS_SIZE-1:0]         remaining,
  output logic [LANES-1:0][IDX_W-1:0] lane_pos,
  output logic [LANES-1:0]            lane_vld,
  output logic [BUS_SIZE-1:0]         next_mask
);

  logic [BUS_SIZE-1:0] m;
  logic                found;

  always_comb begin
    m        = remaining;
    lane_pos = '0;
    lane_vld = '0;
    found    = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      found = 1'b0;
      for (int unsigned p = 0; p < BUS_SIZE; p++) begin
        if (!found && m[p]) begin
          found       = 1'b1;
          lane_pos[l] = IDX_W'(p);
          m[p]        = 1'b0;
        end
      end
      lane_vld[l] = found;
    end
    next_mask = m;
  end

endmodule

// File: rtl/compute_unit_mlane.sv
// Multi-lane sparse compute unit. Buffers one IFM chunk and one filter chunk
// (sparsemap + packed nonzeros), ANDs the maps and consumes up to LANES
// matched positions per cycle, multiply-accumulating them. At chunk end the
// incoming partial sum is added and the result offered on valid/ready.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   ifm_*    / filter_*             chunk write side (map, packed data, valid/ready)
//   acc_dat_i                       partial sum, sampled in the last COMPUTE cycle
//   acc_val_o, acc_dat_o, acc_rdy_i result handshake
//   chunk_end_o                     1-cycle pulse on COMPUTE->OUT
//   busy_o                          FSM not idle
module compute_unit_mlane
  import cu_pkg::*;
#(
  parameter int unsigned BUS_SIZE = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LANES    = 2,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SIGNED   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BUS_SIZE-1:0]        ifm_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0] ifm_nonzero_data_i,
  input  logic                       ifm_wr_valid_i,
  output logic                       ifm_wr_ready_o,
  input  logic [BUS_SIZE-1:0]        filter_sparsemap_i,
  input  logic [BUS_SIZE*DATA_W-1:0] filter_nonzero_data_i,
  input  logic                       filter_wr_valid_i,
  output logic                       filter_wr_ready_o,
  input  logic [ACC_W-1:0]           acc_dat_i,
  output logic                       acc_val_o,
  output logic [ACC_W-1:0]           acc_dat_o,
  input  logic                       acc_rdy_i,
  output logic                       chunk_end_o,
  output logic                       busy_o
);

  state_e state, state_nxt;

  logic                       ifm_full, filt_full;
  logic [BUS_SIZE-1:0]        ifm_map, filt_map;
  logic [BUS_SIZE*DATA_W-1:0] ifm_data, filt_data;
  logic                       ifm_cap, filt_cap, both_next, free_bufs;
  logic [BUS_SIZE-1:0]        ifm_map_nxt, filt_map_nxt;

  logic [BUS_SIZE-1:0]        remaining, next_mask;
  logic [LANES-1:0][IDX_W-1:0] lane_pos;
  logic [LANES-1:0]           lane_vld;
  logic                       last, load_rem;

  logic [LANES-1:0][IDX_W-1:0]    ia, fa;
  logic [LANES-1:0][DATA_W-1:0]   op_a, op_b;
  logic [LANES-1:0][2*DATA_W-1:0] prod_wide;
  logic [LANES-1:0][ACC_W-1:0]    lane_prod;
  logic [ACC_W-1:0]               sum_prod, acc;

  assign ifm_cap  = ifm_wr_valid_i & ~ifm_full;
  assign filt_cap = filter_wr_valid_i & ~filt_full;
  assign ifm_wr_ready_o    = ~ifm_full;
  assign filter_wr_ready_o = ~filt_full;

  // A capture on the same edge as the FSM transition counts as full, so the
  // mask must be formed from the incoming maps rather than the registers.
  assign ifm_map_nxt  = ifm_cap  ? ifm_sparsemap_i    : ifm_map;
  assign filt_map_nxt = filt_cap ? filter_sparsemap_i : filt_map;
  assign both_next    = (ifm_full | ifm_cap) & (filt_full | filt_cap);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifm_full  <= 1'b0;
      ifm_map   <= '0;
      ifm_data  <= '0;
      filt_full <= 1'b0;
      filt_map  <= '0;
      filt_data <= '0;
    end else begin
      if (ifm_cap) begin
        ifm_full <= 1'b1;
        ifm_map  <= ifm_sparsemap_i;
        ifm_data <= ifm_nonzero_data_i;
      end else if (free_bufs) begin
        ifm_full <= 1'b0;
      end
      if (filt_cap) begin
        filt_full <= 1'b1;
        filt_map  <= filter_sparsemap_i;
        filt_data <= filter_nonzero_data_i;
      end else if (free_bufs) begin
        filt_full <= 1'b0;
      end
    end
  end

  match_picker #(
    .BUS_SIZE (BUS_SIZE),
    .LANES    (LANES)
  ) u_picker (
    .remaining (remaining),
    .lane_pos  (lane_pos),
    .lane_vld  (lane_vld),
    .next_mask (next_mask)
  );

  assign last = (next_mask == '0);

  always_comb begin
    ia        = '0;
    fa        = '0;
    op_a      = '0;
    op_b      = '0;
    prod_wide = '0;
    lane_prod = '0;
    sum_prod  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ia[l]   = rank_below(MAX_BUS'(ifm_map),  int'(lane_pos[l]));
      fa[l]   = rank_below(MAX_BUS'(filt_map), int'(lane_pos[l]));
      op_a[l] = ifm_data[int'(ia[l])*DATA_W +: DATA_W];
      op_b[l] = filt_data[int'(fa[l])*DATA_W +: DATA_W];
      if (SIGNED != 0) begin
        prod_wide[l] = (2*DATA_W)'($signed(op_a[l])) * (2*DATA_W)'($signed(op_b[l]));
        lane_prod[l] = ACC_W'($signed(prod_wide[l]));
      end else begin
        prod_wide[l] = (2*DATA_W)'(op_a[l]) * (2*DATA_W)'(op_b[l]);
        lane_prod[l] = ACC_W'(prod_wide[l]);
      end
      if (lane_vld[l]) sum_prod = sum_prod + lane_prod[l];
    end
  end

  always_comb begin
    state_nxt = state;
    free_bufs = 1'b0;
    case (state)
      IDLE:    if (both_next) state_nxt = COMPUTE;
      COMPUTE: begin
        if (last) begin
          free_bufs = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT:     if (acc_rdy_i) state_nxt = both_next ? COMPUTE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_rem = (state_nxt == COMPUTE) && (state != COMPUTE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      remaining   <= '0;
      acc         <= '0;
      acc_dat_o   <= '0;
      chunk_end_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      chunk_end_o <= (state == COMPUTE) && last;
      if (load_rem) begin
        remaining <= ifm_map_nxt & filt_map_nxt;
      end else if (state == COMPUTE) begin
        remaining <= next_mask;
      end
      if (state == COMPUTE) begin
        if (last) acc_dat_o <= acc + sum_prod + acc_dat_i;
        else      acc       <= acc + sum_prod;
      end else if (state == OUT && acc_rdy_i) begin
        acc <= '0;
      end
    end
  end

  assign acc_val_o = (state == OUT);
  assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_compute_unit_mlane.sv
module tb_compute_unit_mlane;

  localparam int unsigned BUS_SIZE = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ACC_W    = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [BUS_SIZE-1:0]        ifm_sparsemap_i, filter_sparsemap_i;
  logic [BUS_SIZE*DATA_W-1:0] ifm_nonzero_data_i, filter_nonzero_data_i;
  logic                       ifm_wr_valid_i, filter_wr_valid_i;
  logic                       ifm_wr_ready_o, filter_wr_ready_o;
  logic [ACC_W-1:0]           acc_dat_i, acc_dat_o;
  logic                       acc_val_o, acc_rdy_i, chunk_end_o, busy_o;

  int unsigned passed = 0;
  int unsigned total  = 0;

  compute_unit_mlane #(
    .BUS_SIZE (BUS_SIZE),
    .DATA_W   (DATA_W),
    .LANES    (2),
    .ACC_W    (ACC_W),
    .SIGNED   (1)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .ifm_sparsemap_i       (ifm_sparsemap_i),
    .ifm_nonzero_data_i    (ifm_nonzero_data_i),
    .ifm_wr_valid_i        (ifm_wr_valid_i),
    .ifm_wr_ready_o        (ifm_wr_ready_o),
    .filter_sparsemap_i    (filter_sparsemap_i),
    .filter_nonzero_data_i (filter_nonzero_data_i),
    .filter_wr_valid_i     (filter_wr_valid_i),
    .filter_wr_ready_o     (filter_wr_ready_o),
    .acc_dat_i             (acc_dat_i),
    .acc_val_o             (acc_val_o),
    .acc_dat_o             (acc_dat_o),
    .acc_rdy_i             (acc_rdy_i),
    .chunk_end_o           (chunk_end_o),
    .busy_o                (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive both chunks for one cycle; they are captured on the next edge.
  task automatic load_chunks(input logic [7:0] imap, input logic [63:0] idat,
                             input logic [7:0] fmap, input logic [63:0] fdat);
    ifm_sparsemap_i       = imap;
    ifm_nonzero_data_i    = idat;
    filter_sparsemap_i    = fmap;
    filter_nonzero_data_i = fdat;
    ifm_wr_valid_i        = 1'b1;
    filter_wr_valid_i     = 1'b1;
    tick();
    ifm_wr_valid_i        = 1'b0;
    filter_wr_valid_i     = 1'b0;
  endtask

  // Counts COMPUTE cycles until the result appears (bounded).
  task automatic wait_result(output int unsigned n);
    n = 0;
    while (!acc_val_o && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic handshake();
    acc_rdy_i = 1'b1;
    tick();
    acc_rdy_i = 1'b0;
  endtask

  logic [63:0] d_seq, d_two, d_t4i, d_t4f, d_t3i, d_t3f;
  int unsigned n;

  initial begin
    for (int k = 0; k < 8; k++) begin
      d_seq[k*8 +: 8] = 8'(k + 1);
      d_two[k*8 +: 8] = 8'd2;
    end
    d_t4i = 64'h0000_0000_0000_0704;   // rank0=4, rank1=7
    d_t4f = 64'h0000_0000_0000_0003;   // rank0=3
    d_t3i = 64'h0000_0000_0000_00FD;   // -3
    d_t3f = 64'h0000_0000_0000_0005;

    rst_i = 1'b1;
    ifm_sparsemap_i = '0; filter_sparsemap_i = '0;
    ifm_nonzero_data_i = '0; filter_nonzero_data_i = '0;
    ifm_wr_valid_i = 1'b0; filter_wr_valid_i = 1'b0;
    acc_dat_i = '0; acc_rdy_i = 1'b0;
    tick(); tick();
    check_eq("rst_ifm_ready",  32'(ifm_wr_ready_o), 32'd1);
    check_eq("rst_filt_ready", 32'(filter_wr_ready_o), 32'd1);
    check_eq("rst_val",        32'(acc_val_o), 32'd0);
    check_eq("rst_dat",        acc_dat_o, 32'd0);
    check_eq("rst_busy",       32'(busy_o), 32'd0);
    check_eq("rst_chunk_end",  32'(chunk_end_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // 1: full dense chunk, 8 matches over 2 lanes
    acc_dat_i = 32'd10;
    load_chunks(8'hFF, d_seq, 8'hFF, d_two);
    check_eq("t1_busy", 32'(busy_o), 32'd1);
    wait_result(n);
    check_eq("t1_cycles", n, 32'd4);
    check_eq("t1_result", acc_dat_o, 32'd82);
    check_eq("t1_chunk_end", 32'(chunk_end_o), 32'd1);
    handshake();
    check_eq("t1_idle", 32'(busy_o), 32'd0);

    // 2: no overlap -> single COMPUTE cycle, result is partial sum only
    acc_dat_i = 32'd7;
    load_chunks(8'h0F, d_seq, 8'hF0, d_two);
    wait_result(n);
    check_eq("t2_cycles", n, 32'd1);
    check_eq("t2_chunk_end", 32'(chunk_end_o), 32'd1);
    check_eq("t2_result", acc_dat_o, 32'd7);
    tick();
    check_eq("t2_pulse_end", 32'(chunk_end_o), 32'd0);
    handshake();

    // 3: signed product
    acc_dat_i = 32'd0;
    load_chunks(8'h01, d_t3i, 8'h01, d_t3f);
    wait_result(n);
    check_eq("t3_result", acc_dat_o, 32'hFFFF_FFF1);
    handshake();

    // 4 + 5: rank indexing, then backpressure with preload
    load_chunks(8'h81, d_t4i, 8'h80, d_t4f);
    wait_result(n);
    check_eq("t4_result", acc_dat_o, 32'd21);
    check_eq("t5_ready_in_out", 32'(ifm_wr_ready_o), 32'd1);
    load_chunks(8'h01, d_t3i, 8'h01, d_t3f);
    check_eq("t5_ifm_ready_low",  32'(ifm_wr_ready_o), 32'd0);
    check_eq("t5_filt_ready_low", 32'(filter_wr_ready_o), 32'd0);
    for (int c = 0; c < 4; c++) tick();
    check_eq("t5_hold_val", 32'(acc_val_o), 32'd1);
    check_eq("t5_hold_dat", acc_dat_o, 32'd21);
    handshake();
    check_eq("t5_compute_val", 32'(acc_val_o), 32'd0);
    check_eq("t5_compute_busy", 32'(busy_o), 32'd1);
    wait_result(n);
    check_eq("t5_next_result", acc_dat_o, 32'hFFFF_FFF1);
    handshake();

    // 6: reset mid-COMPUTE
    acc_dat_i = 32'd10;
    load_chunks(8'hFF, d_seq, 8'hFF, d_two);
    tick();
    #1 rst_i = 1'b1;
    #1;
    check_eq("t6_busy",  32'(busy_o), 32'd0);
    check_eq("t6_ready", 32'(ifm_wr_ready_o & filter_wr_ready_o), 32'd1);
    check_eq("t6_val",   32'(acc_val_o), 32'd0);
    check_eq("t6_dat",   acc_dat_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    acc_dat_i = 32'd7;
    load_chunks(8'h0F, d_seq, 8'hF0, d_two);
    wait_result(n);
    check_eq("t6_after_reset", acc_dat_o, 32'd7);
    handshake();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
